// File: rtl/console_pkg.sv
// Shared state encoding and control-character codes
// for the text console writer.
package console_pkg;

    localparam int CON_CHAR_W = 9;

    typedef enum logic [2:0] {
        INIT_CLEAR,
        IDLE,
        SCROLL_RD,
        SCROLL_WR,
        CLEAR_ROW,
        CLEAR_ALL
    } console_state_t;

    localparam logic [CON_CHAR_W-1:0] CH_SPACE = 9'd32;
    localparam logic [CON_CHAR_W-1:0] CH_BS    = 9'd8;
    localparam logic [CON_CHAR_W-1:0] CH_LF    = 9'd10;
    localparam logic [CON_CHAR_W-1:0] CH_FF    = 9'd12;
    localparam logic [CON_CHAR_W-1:0] CH_CR    = 9'd13;

endpackage

// File: rtl/console_fill.sv
// Address sweep used to blank a range of the text RAM,
// one cell per clock from base to base+len-1.
module console_fill #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              active,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active <= 1'b0;
            cnt    <= '0;
            base_q <= '0;
            len_q  <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            base_q <= base;
            len_q  <= len;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    assign addr = base_q + cnt;
    assign done = active && (cnt == len_q - ADDR_W'(1));

endmodule

// File: rtl/text_console_writer.sv
// Cursor-tracking character writer for the COLS x ROWS text RAM,
// with line wrap, hardware scroll and screen/row clearing.
module text_console_writer
    import console_pkg::*;
#(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int CHAR_W = 9,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [CHAR_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [CHAR_W-1:0] ram_rdata,
    output logic [5:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] CELLS     = ADDR_W'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(COLS * (ROWS - 1));
    localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [5:0]        X_MAX     = 6'(COLS - 1);
    localparam logic [4:0]        Y_MAX     = 5'(ROWS - 1);

    localparam logic [CHAR_W-1:0] SPACE = CHAR_W'(CH_SPACE);
    localparam logic [CHAR_W-1:0] BS    = CHAR_W'(CH_BS);
    localparam logic [CHAR_W-1:0] LF    = CHAR_W'(CH_LF);
    localparam logic [CHAR_W-1:0] FF    = CHAR_W'(CH_FF);
    localparam logic [CHAR_W-1:0] CR    = CHAR_W'(CH_CR);

    console_state_t state, state_n;

    logic [ADDR_W-1:0] idx, idx_n;
    logic [5:0]        cx_n;
    logic [4:0]        cy_n;
    logic              we_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [CHAR_W-1:0] wdata_n;
    logic [ADDR_W-1:0] raddr_n;
    logic              newline;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W-1:0] fill_len;
    logic              fill_active;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_done;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] bs_addr;
    logic              is_print;

    assign cur_addr = ADDR_W'(cursor_y) * COLS_A + ADDR_W'(cursor_x);
    assign bs_addr  = cur_addr - ADDR_W'(1);
    assign is_print = (in_char >= SPACE);

    // Row clear follows the scroll copy; everything else blanks the screen.
    assign fill_base = (state == SCROLL_WR || state == CLEAR_ROW) ? LAST_ROW : '0;
    assign fill_len  = (state == SCROLL_WR || state == CLEAR_ROW) ? COLS_A : CELLS;

    console_fill #(
        .ADDR_W (ADDR_W)
    ) u_fill (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (fill_start),
        .base    (fill_base),
        .len     (fill_len),
        .active  (fill_active),
        .addr    (fill_addr),
        .done    (fill_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= INIT_CLEAR;
            idx       <= '0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_raddr <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cursor_x  <= cx_n;
            cursor_y  <= cy_n;
            ram_we    <= we_n;
            ram_waddr <= waddr_n;
            ram_wdata <= wdata_n;
            ram_raddr <= raddr_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cx_n       = cursor_x;
        cy_n       = cursor_y;
        we_n       = 1'b0;
        waddr_n    = ram_waddr;
        wdata_n    = ram_wdata;
        raddr_n    = ram_raddr;
        newline    = 1'b0;
        fill_start = 1'b0;

        unique case (state)
            INIT_CLEAR, CLEAR_ALL, CLEAR_ROW: begin
                if (fill_active) begin
                    we_n    = 1'b1;
                    waddr_n = fill_addr;
                    wdata_n = SPACE;
                    if (fill_done) begin
                        state_n = IDLE;
                    end
                end else begin
                    fill_start = 1'b1;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    unique case (1'b1)
                        is_print: begin
                            we_n    = 1'b1;
                            waddr_n = cur_addr;
                            wdata_n = in_char;
                            if (cursor_x == X_MAX) begin
                                cx_n    = '0;
                                newline = 1'b1;
                            end else begin
                                cx_n = cursor_x + 6'd1;
                            end
                        end
                        (in_char == LF): begin
                            newline = 1'b1;
                        end
                        (in_char == CR): begin
                            cx_n = '0;
                        end
                        (in_char == FF): begin
                            cx_n       = '0;
                            cy_n       = '0;
                            fill_start = 1'b1;
                            state_n    = CLEAR_ALL;
                        end
                        (in_char == BS): begin
                            if (cursor_x != '0) begin
                                cx_n    = cursor_x - 6'd1;
                                we_n    = 1'b1;
                                waddr_n = bs_addr;
                                wdata_n = SPACE;
                            end
                        end
                        default: ;
                    endcase
                    // Bottom row: stay put and shift the screen up instead.
                    if (newline) begin
                        if (cursor_y == Y_MAX) begin
                            cx_n    = '0;
                            idx_n   = '0;
                            raddr_n = COLS_A;
                            state_n = SCROLL_RD;
                        end else begin
                            cy_n = cursor_y + 5'd1;
                        end
                    end
                end
            end
            SCROLL_RD: begin
                state_n = SCROLL_WR;
            end
            SCROLL_WR: begin
                we_n    = 1'b1;
                waddr_n = idx;
                wdata_n = ram_rdata;
                if (idx == COPY_LAST) begin
                    fill_start = 1'b1;
                    state_n    = CLEAR_ROW;
                end else begin
                    idx_n   = idx + ADDR_W'(1);
                    raddr_n = idx + COLS_A + ADDR_W'(1);
                    state_n = SCROLL_RD;
                end
            end
            default: begin
                state_n = INIT_CLEAR;
            end
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
